// File: rtl/flash_arbiter_pkg.sv
// flash_arbiter_pkg: shared definitions for the flash arbiter slice.
//   arb_state_e   - 3-bit arbiter FSM state encoding
//   FL_CMD_*      - encoding of a requester's req_we bit
//   FL_*_DEF      - default flash address / data widths
//   idx_width()   - width of a requester index (at least 1 bit)
package flash_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_WAIT_END   = 3'd3,
    ST_DONE       = 3'd4
  } arb_state_e;

  localparam logic FL_CMD_READ  = 1'b0;
  localparam logic FL_CMD_WRITE = 1'b1;

  localparam int unsigned FL_AW_DEF = 16;
  localparam int unsigned FL_DW_DEF = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flash_arbiter_rr_pick.sv
// flash_arbiter_rr_pick: combinational round-robin priority pick.
// Scans req starting at ptr and wrapping NREQ-1 -> 0; the first set bit wins.
//   req   in   NREQ  pending requests
//   ptr   in   PW    index with highest priority this cycle
//   grant out  NREQ  one-hot winner (all zero when nothing pending)
//   idx   out  PW    binary index of the winner
//   valid out  1     at least one request pending
module flash_arbiter_rr_pick
  import flash_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned PW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    logic [PW-1:0] cand;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = ptr;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
      cand = (cand == PW'(NREQ - 1)) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// flash_arbiter: shares one flash_ctl SPI flash controller between NREQ
// requesters with round-robin arbitration. Each granted request produces one
// read or write strobe, waits for the controller's busy to rise and fall, then
// returns a one-cycle ack (and read data) to the winner.
// Optional feature macro: FLASH_ARB_TIMEOUT_EN - per-wait-phase timeout of
// TO_CYC cycles; expiry completes the transaction with err=1.
//   clk        in   1        clock, posedge
//   nreset     in   1        asynchronous reset, active-high
//   req        in   NREQ     request per requester, held until its ack
//   req_we     in   NREQ     1=write, 0=read
//   req_addr   in   NREQ*AW  requester i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW  requester i at [i*DW +: DW]
//   ack        out  NREQ     one-cycle one-hot completion pulse
//   err        out  1        timeout abort, coincident with ack
//   rdata      out  DW       read data, valid with ack, held until next read
//   fl_read    out  1        one-cycle read strobe
//   fl_write   out  1        one-cycle write strobe
//   fl_addr    out  AW       address, stable from strobe to completion
//   fl_din     out  DW       write data, stable from strobe to completion
//   fl_dout    in   DW       read data from flash_ctl
//   fl_busy    in   1        flash_ctl busy
module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned AW     = FL_AW_DEF,
  parameter int unsigned DW     = FL_DW_DEF,
  parameter int unsigned TO_CYC = 4095
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [DW-1:0]      rdata,
  output logic               fl_read,
  output logic               fl_write,
  output logic [AW-1:0]      fl_addr,
  output logic [DW-1:0]      fl_din,
  input  logic [DW-1:0]      fl_dout,
  input  logic               fl_busy
);

  localparam int unsigned PW = idx_width(NREQ);

  if (NREQ < 1 || NREQ > 8 || TO_CYC < 1) begin : g_bad_param
    $error("flash_arbiter: NREQ must be 1..8 and TO_CYC at least 1");
  end

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt_q;
  logic            we_q;

  logic [NREQ-1:0] pick_grant;
  logic [PW-1:0]   pick_idx;
  logic            pick_valid;

  logic            grant_en;
  logic            rd_d, wr_d, err_d, rdata_ld;
  logic [NREQ-1:0] ack_d;
  logic            timed_out;

  flash_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt_q;

  // Reloaded on entry to each wait phase: from ISSUE into WAIT_START and
  // from WAIT_START into WAIT_END.
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      to_cnt_q <= '0;
    end else if (state_q == ST_ISSUE || (state_q == ST_WAIT_START && fl_busy)) begin
      to_cnt_q <= TW'(TO_CYC);
    end else if ((state_q == ST_WAIT_START || state_q == ST_WAIT_END) && to_cnt_q != '0) begin
      to_cnt_q <= to_cnt_q - 1'b1;
    end
  end

  assign timed_out = (to_cnt_q == '0);
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Strobes, ack and err are registered: the decision made in ISSUE shows as
  // a strobe in the first WAIT_START cycle, and the completion decision shows
  // as ack during DONE.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    ack_d    = '0;
    err_d    = 1'b0;
    rdata_ld = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !fl_busy) begin
          grant_en = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wr_d    = (we_q == FL_CMD_WRITE);
        rd_d    = (we_q == FL_CMD_READ);
        state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (fl_busy) begin
          state_d = ST_WAIT_END;
        end else if (timed_out) begin
          state_d = ST_DONE;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      ST_WAIT_END: begin
        if (!fl_busy) begin
          state_d  = ST_DONE;
          ack_d    = gnt_q;
          rdata_ld = (we_q == FL_CMD_READ);
        end else if (timed_out) begin
          state_d = ST_DONE;
          ack_d   = gnt_q;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      we_q     <= 1'b0;
      fl_addr  <= '0;
      fl_din   <= '0;
      fl_read  <= 1'b0;
      fl_write <= 1'b0;
      ack      <= '0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      fl_read  <= rd_d;
      fl_write <= wr_d;
      ack      <= ack_d;
      err      <= err_d;
      if (rdata_ld) rdata <= fl_dout;
      if (grant_en) begin
        gnt_q   <= pick_grant;
        we_q    <= req_we[pick_idx];
        fl_addr <= req_addr[pick_idx*AW +: AW];
        fl_din  <= req_wdata[pick_idx*DW +: DW];
        ptr_q   <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
`timescale 1ns/1ps
module tb_flash_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 8;
`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int BUSY_LEN = 12;
`else
  localparam int BUSY_LEN = 20;
`endif

  logic               clk;
  logic               nreset;
  logic [NREQ-1:0]    req, req_we, ack;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic               err, fl_read, fl_write, fl_busy;
  logic [DW-1:0]      rdata, fl_din, fl_dout;
  logic [AW-1:0]      fl_addr;

  logic force_busy, model_en, model_busy;
  int   bcnt;
  int   cyc = 0;

  typedef struct { logic [NREQ-1:0] ack; logic err; logic [DW-1:0] rdata;
                   logic we; logic [AW-1:0] addr; logic [DW-1:0] din; } txn_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] din; int cyc; } strb_t;
  typedef struct { logic [NREQ-1:0] ack; logic err; logic [DW-1:0] rdata;
                   logic [AW-1:0] addr; logic [DW-1:0] din; int cyc; } ack_t;

  txn_t  exp_q[$];
  strb_t strb_q[$];
  ack_t  ack_q[$];

  int errors = 0;
  int checks = 0;
  int both_cnt = 0;
  int gap_viol = 0;
  bit strobe_seen = 0;
  bit busy_between = 0;
  int exp_ptr = 0;
  logic [DW-1:0] exp_rdata = '0;
  int last_strb_cyc, last_ack_cyc;

  flash_arbiter #(
    .NREQ   (NREQ),
    .AW     (AW),
    .DW     (DW),
    .TO_CYC (15)
  ) dut (
    .clk       (clk),
    .nreset    (nreset),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .fl_read   (fl_read),
    .fl_write  (fl_write),
    .fl_addr   (fl_addr),
    .fl_din    (fl_din),
    .fl_dout   (fl_dout),
    .fl_busy   (fl_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash controller stand-in: busy rises the cycle after a strobe and stays
  // high for BUSY_LEN cycles.
  always @(posedge clk or posedge nreset) begin
    if (nreset) begin
      model_busy <= 1'b0;
      bcnt       <= 0;
    end else if (model_en && (fl_read || fl_write)) begin
      model_busy <= 1'b1;
      bcnt       <= BUSY_LEN - 1;
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end else begin
      model_busy <= 1'b0;
    end
  end
  assign fl_busy = force_busy | model_busy;

  always @(negedge clk) begin
    if (nreset) begin
      strobe_seen  = 1'b0;
      busy_between = 1'b0;
    end else begin
      if (fl_read || fl_write) begin
        if (fl_read && fl_write) both_cnt++;
        if (strobe_seen && !busy_between) gap_viol++;
        strobe_seen  = 1'b1;
        busy_between = 1'b0;
        strb_q.push_back('{we: fl_write, addr: fl_addr, din: fl_din, cyc: cyc});
      end else if (fl_busy) begin
        busy_between = 1'b1;
      end
      if (ack != '0 || err) begin
        ack_q.push_back('{ack: ack, err: err, rdata: rdata, addr: fl_addr, din: fl_din, cyc: cyc});
        if (err) strobe_seen = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din);
    req_we[idx]              = we;
    req_addr[idx*AW +: AW]   = addr;
    req_wdata[idx*DW +: DW]  = din;
  endtask

  // Two-requester round-robin reference: the pointer holder wins if pending.
  function automatic int next_grant(input logic [NREQ-1:0] pend);
    return pend[exp_ptr] ? exp_ptr : (exp_ptr + 1) % NREQ;
  endfunction

  task automatic push_exp(input int idx, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] din, input logic e_err);
    txn_t t;
    t.ack      = '0;
    t.ack[idx] = 1'b1;
    t.err      = e_err;
    t.we       = we;
    t.addr     = addr;
    t.din      = din;
    if (!we && !e_err) exp_rdata = fl_dout;
    t.rdata    = exp_rdata;
    exp_q.push_back(t);
    exp_ptr = (idx + 1) % NREQ;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_ack(input string tag, input bit drop);
    txn_t  e;
    strb_t s;
    ack_t  o;
    int    n = 0;
    while (ack_q.size() == 0 && n < 400) begin tick(1); n++; end
    check({tag, "_ack_seen"}, 32'(ack_q.size() != 0), 32'd1);
    if (ack_q.size() == 0 || exp_q.size() == 0) return;
    o = ack_q.pop_front();
    e = exp_q.pop_front();
    check({tag, "_strobe_count"}, 32'(strb_q.size()), 32'd1);
    if (strb_q.size() != 0) begin
      s = strb_q.pop_front();
      last_strb_cyc = s.cyc;
      check({tag, "_strobe_we"}, 32'(s.we), 32'(e.we));
      check({tag, "_strobe_addr"}, 32'(s.addr), 32'(e.addr));
      if (e.we) check({tag, "_strobe_din"}, 32'(s.din), 32'(e.din));
    end
    last_ack_cyc = o.cyc;
    check({tag, "_ack"}, 32'(o.ack), 32'(e.ack));
    check({tag, "_err"}, 32'(o.err), 32'(e.err));
    check({tag, "_rdata"}, 32'(o.rdata), 32'(e.rdata));
    check({tag, "_addr_held"}, 32'(o.addr), 32'(e.addr));
    if (e.we) check({tag, "_din_held"}, 32'(o.din), 32'(e.din));
    if (drop) req = req & ~o.ack;
  endtask

  initial begin
    int k, g, n;
    nreset = 1'b1;  req = '0;  req_we = '0;  req_addr = '0;  req_wdata = '0;
    fl_dout = '0;  force_busy = 1'b0;  model_en = 1'b1;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_strobes", 32'({fl_read, fl_write}), 32'd0);
    check("rst_addr", 32'(fl_addr), 32'd0);
    check("rst_din", 32'(fl_din), 32'd0);
    tick(3);
    nreset = 1'b0;
    tick(2);

    // Single read from requester 0.
    set_req(0, 1'b0, 16'h01AA, 8'h00);
    fl_dout = 8'h55;
    push_exp(0, 1'b0, 16'h01AA, 8'h00, 1'b0);
    k = cyc;
    req[0] = 1'b1;
    wait_ack("rd", 1'b1);
    check("rd_strobe_lat", 32'(last_strb_cyc - k), 32'd2);
    check("rd_ack_lat", 32'(last_ack_cyc - last_strb_cyc), 32'(BUSY_LEN + 2));
    tick(2);

    // Single write from requester 1.
    set_req(1, 1'b1, 16'h01AA, 8'h55);
    fl_dout = 8'hFF;
    push_exp(1, 1'b1, 16'h01AA, 8'h55, 1'b0);
    req[1] = 1'b1;
    wait_ack("wr", 1'b1);
    tick(2);

    // Controller busy while idle: hold off until busy drops.
    force_busy = 1'b1;
    set_req(0, 1'b0, 16'h0ABC, 8'h00);
    fl_dout = 8'h5A;
    push_exp(0, 1'b0, 16'h0ABC, 8'h00, 1'b0);
    req[0] = 1'b1;
    tick(10);
    check("busy_idle_no_strobe", 32'(strb_q.size()), 32'd0);
    k = cyc;
    force_busy = 1'b0;
    wait_ack("busy_idle", 1'b1);
    check("busy_idle_lat", 32'(last_strb_cyc - k), 32'd2);
    tick(2);

    // Contention: both held high for four transactions.
    set_req(0, 1'b0, 16'h0100, 8'h00);
    set_req(1, 1'b1, 16'h0200, 8'h3C);
    fl_dout = 8'hC3;
    for (int i = 0; i < 4; i++) begin
      g = next_grant(2'b11);
      push_exp(g, req_we[g], req_addr[g*AW +: AW], req_wdata[g*DW +: DW], 1'b0);
    end
    req = 2'b11;
    for (int i = 0; i < 3; i++) wait_ack("cont", 1'b0);
    wait_ack("cont", 1'b0);
    req = '0;
    tick(3);

    // Requester drops req right after the strobe; transaction still acks.
    set_req(1, 1'b1, 16'h0333, 8'h77);
    push_exp(1, 1'b1, 16'h0333, 8'h77, 1'b0);
    req[1] = 1'b1;
    n = 0;
    while (strb_q.size() == 0 && n < 50) begin tick(1); n++; end
    req[1] = 1'b0;
    wait_ack("drop", 1'b1);
    tick(2);

`ifdef FLASH_ARB_TIMEOUT_EN
    // Busy never rises: abort with err after TO_CYC+1 cycles.
    model_en = 1'b0;
    set_req(0, 1'b0, 16'h0F0F, 8'h00);
    fl_dout = 8'hEE;
    push_exp(0, 1'b0, 16'h0F0F, 8'h00, 1'b1);
    req[0] = 1'b1;
    wait_ack("timeout", 1'b1);
    check("timeout_lat", 32'(last_ack_cyc - last_strb_cyc), 32'd16);
    model_en = 1'b1;
    tick(2);
`endif

    // Reset in WAIT_END aborts without ack and restarts the pointer at 0.
    set_req(0, 1'b0, 16'h0123, 8'h00);
    fl_dout = 8'h99;
    push_exp(0, 1'b0, 16'h0123, 8'h00, 1'b0);
    req[0] = 1'b1;
    n = 0;
    while (strb_q.size() == 0 && n < 50) begin tick(1); n++; end
    check("mid_strobe_seen", 32'(strb_q.size()), 32'd1);
    tick(5);
    nreset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(ack), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_strobes", 32'({fl_read, fl_write}), 32'd0);
    check("mid_rst_addr", 32'(fl_addr), 32'd0);
    check("mid_rst_din", 32'(fl_din), 32'd0);
    req = '0;
    tick(2);
    nreset = 1'b0;
    void'(exp_q.pop_front());
    strb_q.delete();
    exp_ptr   = 0;
    exp_rdata = '0;
    tick(4);
    check("mid_no_ack", 32'(ack_q.size()), 32'd0);

    set_req(0, 1'b0, 16'h0222, 8'h00);
    set_req(1, 1'b1, 16'h0444, 8'h18);
    fl_dout = 8'h81;
    g = next_grant(2'b11);
    push_exp(g, 1'b0, 16'h0222, 8'h00, 1'b0);
    g = next_grant(2'b10);
    push_exp(g, 1'b1, 16'h0444, 8'h18, 1'b0);
    req = 2'b11;
    wait_ack("post_rst", 1'b1);
    wait_ack("post_rst", 1'b1);
    tick(3);

    check("never_both_strobes", 32'(both_cnt), 32'd0);
    check("busy_between_strobes", 32'(gap_viol), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("no_stray_ack", 32'(ack_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
